// File: rtl/rv_mem_lsu.sv
// rtl/rv_mem_lsu.sv - Q103H load/store unit with D_MEM handshake; watchdog built only with RV_MEM_LSU_TIMEOUT_EN
module rv_mem_lsu #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready_Q104H,
   input  logic              valid_Q103H,
   input  logic              is_load_Q103H,
   input  logic              is_store_Q103H,
   input  logic [2:0]        funct3_Q103H,
   input  logic [1:0]        sel_wb_Q103H,
   input  logic [31:0]       pc_plus4_Q103H,
   input  logic [ADDR_W-1:0] alu_out_Q103H,
   input  logic [DATA_W-1:0] st_data_Q103H,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic              dmem_req_wr_en,
   output logic [DATA_W/8-1:0] dmem_req_byte_en,
   output logic [DATA_W-1:0] dmem_req_wr_data,
   input  logic              dmem_rsp_valid,
   input  logic [DATA_W-1:0] dmem_rsp_data,
   output logic              mem_stall_Q103H,
   output logic              misalign_Q103H,
   output logic              timeout_err,
   output logic [DATA_W-1:0] wb_data_Q104H
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   localparam logic [1:0]  SEL_PC_PLUS4 = 2'd0;
   localparam logic [1:0]  SEL_ALU_OUT  = 2'd1;
   localparam logic [1:0]  SEL_DMEM_RD  = 2'd2;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        size;
   logic [OFF_W-1:0]  off;
   logic              mem_op;
   logic              addr_misaligned;
   logic              access;
   logic              completing;
   logic              rsp_now;
   logic              timeout_now;
   logic              done_q;
   logic              to_q;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] fmt_data;
   logic [DATA_W-1:0] ld_data_q;
   logic [DATA_W-1:0] wb_next;

   assign size   = funct3_Q103H[1:0];
   assign off    = alu_out_Q103H[OFF_W-1:0];
   assign mem_op = valid_Q103H & (is_load_Q103H | is_store_Q103H);

   // Natural alignment check for the access size
   always_comb begin
      addr_misaligned = 1'b0;
      case (size)
         2'd1:    addr_misaligned = alu_out_Q103H[0];
         2'd2:    addr_misaligned = |alu_out_Q103H[1:0];
         2'd3:    addr_misaligned = |alu_out_Q103H[2:0];
         default: addr_misaligned = 1'b0;
      endcase
   end

   assign misalign_Q103H = mem_op & addr_misaligned;
   // done_q masks an instruction that already completed but is still parked waiting for Q104H
   assign access = mem_op & ~addr_misaligned & ~done_q;

   assign dmem_req_addr  = alu_out_Q103H & ~ADDR_W'(NB - 1);
   assign dmem_req_wr_en = is_store_Q103H;

   // Store lane steering: byte enables from size/offset, data replicated across lanes
   always_comb begin
      dmem_req_byte_en = '1;
      dmem_req_wr_data = st_data_Q103H;
      case (size)
         2'd0: begin
            dmem_req_byte_en = NB'(1) << off;
            dmem_req_wr_data = {NB{st_data_Q103H[7:0]}};
         end
         2'd1: begin
            dmem_req_byte_en = NB'(3) << off;
            dmem_req_wr_data = {(NB/2){st_data_Q103H[15:0]}};
         end
         2'd2: begin
            dmem_req_byte_en = NB'(15) << off;
            dmem_req_wr_data = {(NB/4){st_data_Q103H[31:0]}};
         end
         default: begin
            dmem_req_byte_en = '1;
            dmem_req_wr_data = st_data_Q103H;
         end
      endcase
   end

   assign shifted = dmem_rsp_data >> {off, 3'b000};

   // Load alignment: truncate to access size, then sign or zero extend
   always_comb begin
      fmt_data = shifted;
      case (funct3_Q103H)
         3'b000:  fmt_data = DATA_W'($signed(shifted[7:0]));
         3'b001:  fmt_data = DATA_W'($signed(shifted[15:0]));
         3'b010:  fmt_data = DATA_W'($signed(shifted[31:0]));
         3'b100:  fmt_data = DATA_W'(shifted[7:0]);
         3'b101:  fmt_data = DATA_W'(shifted[15:0]);
         3'b110:  fmt_data = DATA_W'(shifted[31:0]);
         default: fmt_data = shifted;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next state, request valid and completion detection
   always_comb begin
      state_next     = state;
      dmem_req_valid = 1'b0;
      completing     = 1'b0;
      rsp_now        = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               dmem_req_valid = 1'b1;
               if (dmem_req_ready) begin
                  if (is_store_Q103H) completing = 1'b1;
                  else                state_next = WAIT_RSP;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
               if (is_store_Q103H) begin
                  completing = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (dmem_rsp_valid) begin
               rsp_now    = 1'b1;
               completing = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout_now) begin
         completing = 1'b1;
         state_next = IDLE;
      end
   end

   assign mem_stall_Q103H = access & ~completing;

   // Load-data register and the parked-completion flag used while Q104H is not ready
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         if (timeout_now)  ld_data_q <= DATA_W'(TIMEOUT_DATA);
         else if (rsp_now) ld_data_q <= fmt_data;
         if (ready_Q104H)     done_q <= 1'b0;
         else if (completing) done_q <= 1'b1;
      end
   end

   // Write-back select; a same-cycle response bypasses the load-data register
   always_comb begin
      wb_next = '0;
      if (misalign_Q103H) begin
         wb_next = '0;
      end else if (timeout_now | (done_q & to_q)) begin
         wb_next = DATA_W'(TIMEOUT_DATA);
      end else begin
         case (sel_wb_Q103H)
            SEL_PC_PLUS4: wb_next = DATA_W'(pc_plus4_Q103H);
            SEL_ALU_OUT:  wb_next = DATA_W'(alu_out_Q103H);
            SEL_DMEM_RD:  wb_next = rsp_now ? fmt_data : ld_data_q;
            default:      wb_next = '0;
         endcase
      end
   end

   // Q104H pipeline register
   always_ff @(posedge clk) begin
      if (rst)                                  wb_data_Q104H <= '0;
      else if (ready_Q104H & ~mem_stall_Q103H)  wb_data_Q104H <= wb_next;
   end

`ifdef RV_MEM_LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wd_cnt;

   assign timeout_now = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Watchdog counter runs while a request or response is outstanding
   always_ff @(posedge clk) begin
      if (rst)                                       wd_cnt <= '0;
      else if ((state != IDLE) && (state_next != IDLE)) wd_cnt <= wd_cnt + 1'b1;
      else                                           wd_cnt <= '0;
   end

   // Sticky error plus a flag marking a parked instruction that ended by timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_err <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         if (timeout_now) timeout_err <= 1'b1;
         if (ready_Q104H)      to_q <= 1'b0;
         else if (timeout_now) to_q <= 1'b1;
      end
   end
`else
   // No watchdog: the FSM waits indefinitely (expression is constant 0)
   assign timeout_now = (TIMEOUT_CYC < 0);
   assign to_q        = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mem_lsu.sv
// tb/tb_rv_mem_lsu.sv - scoreboard bench for rv_mem_lsu
module tb_rv_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready_Q104H;
   logic        valid_Q103H;
   logic        is_load_Q103H;
   logic        is_store_Q103H;
   logic [2:0]  funct3_Q103H;
   logic [1:0]  sel_wb_Q103H;
   logic [31:0] pc_plus4_Q103H;
   logic [31:0] alu_out_Q103H;
   logic [31:0] st_data_Q103H;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_req_addr;
   logic        dmem_req_wr_en;
   logic [3:0]  dmem_req_byte_en;
   logic [31:0] dmem_req_wr_data;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   logic        mem_stall_Q103H;
   logic        misalign_Q103H;
   logic        timeout_err;
   logic [31:0] wb_data_Q104H;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   rv_mem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .ready_Q104H(ready_Q104H), .valid_Q103H(valid_Q103H),
      .is_load_Q103H(is_load_Q103H), .is_store_Q103H(is_store_Q103H),
      .funct3_Q103H(funct3_Q103H), .sel_wb_Q103H(sel_wb_Q103H),
      .pc_plus4_Q103H(pc_plus4_Q103H), .alu_out_Q103H(alu_out_Q103H),
      .st_data_Q103H(st_data_Q103H), .dmem_req_valid(dmem_req_valid),
      .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
      .dmem_req_wr_en(dmem_req_wr_en), .dmem_req_byte_en(dmem_req_byte_en),
      .dmem_req_wr_data(dmem_req_wr_data), .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rsp_data(dmem_rsp_data), .mem_stall_Q103H(mem_stall_Q103H),
      .misalign_Q103H(misalign_Q103H), .timeout_err(timeout_err),
      .wb_data_Q104H(wb_data_Q104H)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      case (f3[1:0])
         2'd0:    return 4'b0001 << a[1:0];
         2'd1:    return 4'b0011 << a[1:0];
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
         2'd1:    return {d[15:0], d[15:0]};
         default: return d;
      endcase
   endfunction

   // One instruction through Q103H; memory ready/response timing given in cycles
   task automatic run_op(input string name, input logic [2:0] f3, input bit ld, input bit st,
                         input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] st_d,
                         input logic [31:0] rsp_d, input int rdy_dly, input int rsp_dly,
                         input int q104_dly, input bit stale, input logic [31:0] exp_wb,
                         input int exp_stall, input bit exp_mis);
      logic [31:0] a0, wd0, wb_prev, expv;
      logic [3:0]  be0;
      logic        we0;
      bit          seen = 0, stable = 1, mis_ok = 1, held = 1, done = 0, adv, exp_req;
      int          cyc = 0, acc = -1, stalls = 0, hs = 0;
      exp_req = (ld || st) && !exp_mis;
      exp_q.push_back(exp_wb);
      valid_Q103H = 1'b1; is_load_Q103H = ld; is_store_Q103H = st;
      funct3_Q103H = f3; sel_wb_Q103H = sel; alu_out_Q103H = addr; st_data_Q103H = st_d;
      pc_plus4_Q103H = 32'h8000_0004;
      wb_prev = wb_data_Q104H;
      while (!done && cyc < 60) begin
         dmem_req_ready = (cyc >= rdy_dly);
         dmem_rsp_valid = (acc >= 0 && cyc == acc + rsp_dly) || (stale && cyc == 0);
         dmem_rsp_data  = (stale && cyc == 0) ? 32'hBAD0_BAD0 : rsp_d;
         ready_Q104H    = (cyc >= q104_dly);
         #2;
         if (misalign_Q103H !== exp_mis) mis_ok = 0;
         if (wb_data_Q104H !== wb_prev) held = 0;
         if (dmem_req_valid) begin
            if (!seen) begin
               seen = 1; a0 = dmem_req_addr; be0 = dmem_req_byte_en;
               wd0 = dmem_req_wr_data; we0 = dmem_req_wr_en;
            end else if (dmem_req_addr !== a0 || dmem_req_byte_en !== be0 ||
                         dmem_req_wr_data !== wd0 || dmem_req_wr_en !== we0) begin
               stable = 0;
            end
            if (dmem_req_ready) begin
               hs++;
               acc = cyc;
            end
         end
         if (mem_stall_Q103H) stalls++;
         adv = ready_Q104H && !mem_stall_Q103H;
         @(posedge clk); #1;
         if (adv) done = 1;
         cyc++;
      end
      check({name, ":completed"}, done, 1);
      expv = exp_q.pop_front();
      check({name, ":wb"}, wb_data_Q104H, expv);
      check({name, ":stall_cycles"}, stalls, exp_stall);
      check({name, ":misalign"}, mis_ok, 1);
      check({name, ":wb_held_until_advance"}, held, 1);
      check({name, ":req_seen"}, seen, exp_req);
      if (exp_req) begin
         check({name, ":handshakes"}, hs, 1);
         check({name, ":addr"}, a0, {addr[31:2], 2'b00});
         check({name, ":wr_en"}, we0, st);
         check({name, ":byte_en"}, be0, model_be(f3, addr));
         if (st) check({name, ":wr_data"}, wd0, model_wd(f3, st_d));
         check({name, ":req_stable"}, stable, 1);
      end
      valid_Q103H = 1'b0; is_load_Q103H = 1'b0; is_store_Q103H = 1'b0;
      dmem_rsp_valid = 1'b0; ready_Q104H = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ready_Q104H = 1'b1; valid_Q103H = 1'b0; is_load_Q103H = 1'b0;
      is_store_Q103H = 1'b0; funct3_Q103H = 3'd0; sel_wb_Q103H = 2'd0;
      pc_plus4_Q103H = 32'd0; alu_out_Q103H = 32'd0; st_data_Q103H = 32'd0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      check("reset:wb", wb_data_Q104H, 32'd0);
      check("reset:stall", mem_stall_Q103H, 1'b0);
      check("reset:req_valid", dmem_req_valid, 1'b0);
      check("reset:timeout_err", timeout_err, 1'b0);
      @(posedge clk); #1;

      //     name      f3    ld st sel   addr          st_d          rsp_d        rdy rsp q104 stale exp_wb       stall mis
      run_op("lb",     3'd0, 1, 0, 2'd2, 32'h103,      32'h0,        32'h8000_0000, 0, 1, 0, 0, 32'hFFFF_FF80, 1, 0);
      run_op("lbu",    3'd4, 1, 0, 2'd2, 32'h103,      32'h0,        32'h8000_0000, 0, 1, 0, 0, 32'h0000_0080, 1, 0);
      run_op("lb_pos", 3'd0, 1, 0, 2'd2, 32'h101,      32'h0,        32'h0000_7F00, 0, 1, 0, 0, 32'h0000_007F, 1, 0);
      run_op("lh",     3'd1, 1, 0, 2'd2, 32'h102,      32'h0,        32'h8001_0000, 0, 1, 0, 0, 32'hFFFF_8001, 1, 0);
      run_op("lhu",    3'd5, 1, 0, 2'd2, 32'h102,      32'h0,        32'h8001_0000, 0, 1, 0, 0, 32'h0000_8001, 1, 0);
      run_op("sh",     3'd1, 0, 1, 2'd1, 32'h102,      32'h1234_ABCD, 32'h0,        0, 1, 0, 0, 32'h0000_0102, 0, 0);
      run_op("sb",     3'd0, 0, 1, 2'd1, 32'h101,      32'h0000_00EF, 32'h0,        0, 1, 0, 0, 32'h0000_0101, 0, 0);
      run_op("sw_wait",3'd2, 0, 1, 2'd1, 32'h10,       32'h5566_7788, 32'h0,        2, 1, 0, 0, 32'h0000_0010, 2, 0);
      run_op("lw_wait",3'd2, 1, 0, 2'd2, 32'h40,       32'h0,        32'hCAFE_F00D, 3, 2, 0, 0, 32'hCAFE_F00D, 5, 0);
      run_op("lw_mis", 3'd2, 1, 0, 2'd2, 32'h101,      32'h0,        32'h0,         0, 1, 0, 0, 32'h0,         0, 1);
      run_op("sh_mis", 3'd1, 0, 1, 2'd1, 32'h103,      32'hFFFF,     32'h0,         0, 1, 0, 0, 32'h0,         0, 1);
      run_op("alu",    3'd0, 0, 0, 2'd1, 32'h1234_5678, 32'h0,       32'h0,         0, 1, 0, 0, 32'h1234_5678, 0, 0);
      run_op("pc4",    3'd0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,         0, 1, 0, 0, 32'h8000_0004, 0, 0);
      run_op("sel3",   3'd0, 0, 0, 2'd3, 32'h77,       32'h0,        32'h0,         0, 1, 0, 0, 32'h0,         0, 0);
      run_op("lw_hold",3'd2, 1, 0, 2'd2, 32'h200,      32'h0,        32'h1357_9BDF, 0, 1, 3, 0, 32'h1357_9BDF, 1, 0);

      // Reset while a load waits for its response
      valid_Q103H = 1'b1; is_load_Q103H = 1'b1; funct3_Q103H = 3'd2; sel_wb_Q103H = 2'd2;
      alu_out_Q103H = 32'h300; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
      #2;
      check("rst_mid:req_issued", dmem_req_valid, 1'b1);
      @(posedge clk); #1;
      valid_Q103H = 1'b0; is_load_Q103H = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_mid:wb", wb_data_Q104H, 32'd0);
      @(posedge clk); #1;
      run_op("late_rsp",3'd2, 1, 0, 2'd2, 32'h44,      32'h0,        32'h1122_3344, 2, 1, 0, 1, 32'h1122_3344, 3, 0);

`ifdef RV_MEM_LSU_TIMEOUT_EN
      run_op("lw_tmo", 3'd2, 1, 0, 2'd2, 32'h80,       32'h0,        32'h0,         0, 1000, 0, 0, 32'hDEAD_BEEF, 8, 0);
      check("timeout:err", timeout_err, 1'b1);
`else
      check("timeout:err_tied", timeout_err, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv_mem_lsu.md
Name: rv_mem_lsu

Overview:
- Parametrised load/store unit for the Q103H memory-access stage of the rv core.
- Adds to the plain memory stage:
  - a valid/ready request handshake to D_MEM with a variable-latency response;
  - a pipeline stall output;
  - store byte-lane steering from funct3 and address;
  - load alignment with sign/zero extension;
  - misalignment detection.
- Registers the selected write-back value into Q104H for the WB stage.

Parameters:
- ADDR_W, 32, D_MEM byte-address width.
- DATA_W, 32, data bus width; legal values 32 or 64; NB = DATA_W/8 byte lanes.
- TIMEOUT_CYC, 64, response watchdog limit in cycles; used only with RV_MEM_LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ready_Q104H  in  1  downstream stage accepts Q104H data
- valid_Q103H  in  1  Q103H holds a live instruction
- is_load_Q103H  in  1  instruction is a load
- is_store_Q103H  in  1  instruction is a store
- funct3_Q103H  in  3  RISC-V size/sign code: B/H/W/D, BU/HU/WU; D and WU legal only when DATA_W=64
- sel_wb_Q103H  in  2  SEL_PC_PLUS4, SEL_ALU_OUT or SEL_DMEM_RD
- pc_plus4_Q103H  in  32  PC+4
- alu_out_Q103H  in  ADDR_W  effective address or ALU result
- st_data_Q103H  in  DATA_W  raw rs2 value, unshifted
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts the request
- dmem_req_addr  out  ADDR_W  bus-aligned address (low log2(NB) bits zero)
- dmem_req_wr_en  out  1  1 = store, 0 = load
- dmem_req_byte_en  out  NB  active byte lanes
- dmem_req_wr_data  out  DATA_W  lane-shifted store data
- dmem_rsp_valid  in  1  load response valid
- dmem_rsp_data  in  DATA_W  load response data
- mem_stall_Q103H  out  1  holds Q103H and all earlier stages
- misalign_Q103H  out  1  misaligned access detected
- timeout_err  out  1  sticky watchdog error
- wb_data_Q104H  out  32/DATA_W  registered write-back data

Behaviour:
- Access condition: access = valid_Q103H & (is_load | is_store) & ~misalign.
- Misalignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - A misaligned access issues no request and raises no stall.
  - misalign_Q103H is combinational.
  - The write-back value for that instruction is 0.
- FSM states: IDLE, REQ, WAIT_RSP. Reset puts the FSM in IDLE.
- IDLE:
  - If access, drive dmem_req_valid combinationally in the same cycle.
  - If dmem_req_ready and store: the access completes; stay in IDLE.
  - If dmem_req_ready and load: go to WAIT_RSP.
  - If not ready: go to REQ.
- REQ:
  - Hold dmem_req_valid and all request fields stable until dmem_req_ready.
  - On ready: a store goes to IDLE; a load goes to WAIT_RSP.
- WAIT_RSP:
  - dmem_req_valid = 0.
  - On dmem_rsp_valid, capture formatted data and go to IDLE.
  - A dmem_rsp_valid seen outside WAIT_RSP is ignored.
- Stall:
  - mem_stall_Q103H = access & ~completing, where completing means a store handshake this cycle or a response this cycle.
  - Minimum load latency: accept in cycle N, response in N+1 gives 1 stall cycle.
  - A store accepted in the same cycle gives 0 stall cycles.
- Store steering:
  - off = addr[log2(NB)-1:0].
  - byte_en: B = 1<<off; H = 3<<off; W = 0xF<<off; D = all ones.
  - wr_data = the rs2 low byte/half/word replicated across all lanes.
- Load format:
  - Shift rsp_data right by 8*off.
  - Truncate to the size given by funct3.
  - Sign-extend for B/H/W; zero-extend for BU/HU/WU.
- Write-back mux:
  - SEL_PC_PLUS4 selects pc_plus4 (zero-extended).
  - SEL_ALU_OUT selects alu_out.
  - SEL_DMEM_RD selects formatted load data; if the rsp and load-data register update in the same cycle, the new value wins.
  - Any other selection gives 0.
- Q104H register:
  - wb_data_Q104H updates iff ready_Q104H & ~mem_stall_Q103H.
  - Otherwise it holds its value.
- Reset:
  - wb_data_Q104H = 0, FSM = IDLE, timeout_err = 0, watchdog counter = 0.
  - Reset mid-transaction abandons the access; a late response is dropped.
- Simultaneous events:
  - ready_Q104H = 0 during a completing access: the access still completes and the FSM returns to IDLE.
  - The formatted data is held in an internal register and forwarded when ready_Q104H rises, with no re-issue.

Optional Feature:
- Macro: RV_MEM_LSU_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and WAIT_RSP and clears on leaving them.
  - At TIMEOUT_CYC it sets timeout_err (sticky until rst), forces the FSM to IDLE, and completes the access with write-back data 0xDEADBEEF (or its zero-extension).
- Undefined:
  - No counter is built; timeout_err is tied to 0.
  - The FSM waits indefinitely.

Test Plan:
- LB at addr 0x103, rsp_data 0x80_00_00_00 -> wb_data_Q104H = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at addr 0x102, rs2 0x1234ABCD -> byte_en = 4'b1100, wr_data = 0xABCDABCD, addr = 0x100, 0 stall cycles with ready high.
- LW with dmem_req_ready low for 3 cycles, rsp 2 cycles after accept -> mem_stall high for 5 cycles, request fields stable throughout, wb = rsp_data.
- LW at addr 0x101 -> misalign_Q103H = 1, dmem_req_valid = 0, no stall, wb = 0.
- Load completes while ready_Q104H = 0 for 2 cycles -> wb_data_Q104H updates only when ready rises; rst pulsed in WAIT_RSP -> FSM IDLE, a late rsp is ignored.
- With RV_MEM_LSU_TIMEOUT_EN, TIMEOUT_CYC = 8, no response -> timeout_err rises 8 cycles after entering WAIT_RSP, stall released, wb = 0xDEADBEEF.
